// File: rtl/seq_square_if.sv
// Handshake bundle for the sequential squarer.
// The requester drives start/abort/xin; the squarer returns busy/done/sq.
interface seq_square_if #(
  parameter int N = 16
);
  logic           start;
  logic           abort;
  logic [N-1:0]   xin;
  logic           busy;
  logic           done;
  logic [2*N-1:0] sq;

  modport master (
    output start, abort, xin,
    input  busy, done, sq
  );

  modport slave (
    input  start, abort, xin,
    output busy, done, sq
  );
endinterface

// File: rtl/seq_square.sv
// Sequential unsigned squarer: one shift-add step per clock,
// start/busy/done handshake, abortable while running.
module seq_square #(
  parameter int N = 16
) (
  input  logic       clock,
  input  logic       reset,
  seq_square_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [2*N-1:0] md;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mr;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] sq;
  logic           busy;
  logic           done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      md    <= '0;
      acc   <= '0;
      mr    <= '0;
      cnt   <= '0;
      sq    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            md    <= {{N{1'b0}}, bus.xin};
            mr    <= bus.xin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (mr[0]) acc <= acc + md;
            md  <= md << 1;
            mr  <= mr >> 1;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          sq    <= acc;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sq   = sq;
endmodule
